la_capture_engine: RTL and testbench
====================================

// Module: la_capture_engine
// PURPOSE
//  Parametrised multi-channel capture engine for the logic-analyzer family: arm, qualified
//  pattern/edge trigger, pre/post-trigger ring buffer, optional run-length (RLE) compression,
//  ready/valid readout. Sits between channel synchronisers and the output mux/serialiser.
// PARAMETERS
//  CH     8   channels sampled per clk
//  DEPTH  64  buffer entries, power of 2, >=4; AW = $clog2(DEPTH)
//  TS_W   8   run-length field width; MAXRUN = 2**TS_W-1
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        reset, asynchronous, active-low
//  arm           in   1        start capture (honoured only in IDLE)
//  abort         in   1        return to IDLE from any state
//  ch_in         in   CH       synchronised channel samples
//  trig_pattern  in   CH       trigger compare value
//  trig_mask     in   CH       1 = bit participates; all-zero mask = always match
//  trig_edge     in   1        0 = level match, 1 = match only on first matching cycle
//  rle_en        in   1        1 = RLE entries, 0 = one entry per clk
//  pre_cnt       in   AW       pre-trigger entries; latched on arm; DEPTH-1 max
//  rd_valid      out  1        entry available
//  rd_ready      in   1        consumer accepts entry
//  rd_data       out  TS_W+CH  {run_len, sample}; run_len = extra cycles held
//  rd_last       out  1        high with final (DEPTH-th) entry
//  state         out  2        IDLE=0 PRE=1 POST=2 READ=3
//  triggered     out  1        high from trigger acceptance until return to IDLE
// BEHAVIOUR
//  Reset: state IDLE; rd_valid, rd_last, triggered 0; rd_data 0; pointers/counters 0.
//  Memory contents are not reset.
//  IDLE -> PRE on arm: latch pre_cnt and rle_en. Clear wr_ptr, wr_cnt and match_q.
//  PRE, first cycle: load cur = ch_in, run = 0. No write; trigger not evaluated.
//  Entry rule (PRE/POST), every later cycle:
//   - If ch_in != cur, or run == MAXRUN, or !rle_en: write {run,cur} at wr_ptr, wr_ptr++
//     (wraps mod DEPTH); then cur = ch_in, run = 0.
//   - Else run++.
//   - Flush may occur only at this point, so written data always lags by >=1 cycle.
//  Trigger: match = ((ch_in ^ trig_pattern) & trig_mask) == 0. match_q = match of the
//   previous cycle. Hit = match && (!trig_edge || !match_q).
//  Accepted in PRE when hit && (wr_cnt+1 >= pre_cnt), wr_cnt saturating at DEPTH.
//  Acceptance cycle:
//   - Force-write the pending run.
//   - Trigger sample starts a new run at address trig_ptr = wr_ptr+1.
//   - start_ptr = trig_ptr - pre_cnt (mod DEPTH). Set triggered. -> POST.
//  POST: post_cnt counts entries written starting with the trigger entry; need = DEPTH - pre_cnt.
//   - When need - post_cnt == 1, the pending run is force-written in the next cycle.
//     This covers a trigger with pre_cnt = DEPTH-1.
//   - -> READ after the need-th write.
//  READ: rd_ptr = start_ptr, rd_valid = 1, rd_data = mem[rd_ptr] (combinational).
//   - rd_valid && rd_ready: advance, rd_cnt++.
//   - rd_last = (rd_cnt == DEPTH-1).
//   - Handshake on last -> IDLE next cycle; rd_valid low.
//   - rd_data is held stable while rd_valid && !rd_ready.
//  Entries older than the pre-trigger window (fewer than pre_cnt written) read as stale
//   memory; pre-trigger acceptance prevents this.
//  abort has priority over arm/trigger/handshake: IDLE next cycle; triggered, rd_valid cleared.
//  arm outside IDLE is ignored. pre_cnt/rle_en changes after arm are ignored.
//  Async reset mid-capture or mid-read returns to IDLE immediately; no partial readout.
// STRUCTURE
//  Package la_pkg:
//   - typedef la_state_e (IDLE, PRE, POST, READ)
//   - localparams for state encoding
//   - function entry_w(CH,TS_W)
//  Sub-module la_trigger_unit: pattern/mask compare, match_q register, edge qualify -> hit.
//  Remaining logic (FSM, RLE, ring buffer, readout) stays in this module.
// TESTING
//  1 Reset mid-PRE -> state=0, rd_valid=0, triggered=0 asynchronously; arm restarts cleanly.
//  2 CH=8, DEPTH=16, rle_en=0, pre_cnt=4, ch_in counts 0,1,2..., trigger on mask FF pattern 0x20
//    -> 16 entries 0x1C..0x2B, run=0, rd_last on 0x2B.
//  3 rle_en=1, ch_in = 0x05 held 300 cycles, TS_W=8 -> first entry {255,0x05}, next {43,0x05}.
//  4 trig_edge=1, pattern held matching across arm -> no trigger until the pattern drops and returns.
//    Level mode triggers at once.
//  5 Level hit while wr_cnt+1 < pre_cnt -> ignored; accepted on first hit after qualification.
//  6 rd_ready toggled 1/0 randomly -> rd_data stable when stalled.
//    abort mid-READ -> IDLE next cycle, rd_valid=0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared state encoding and entry sizing for the logic-analyzer capture engine.
package la_pkg;

    localparam logic [1:0] LA_IDLE = 2'd0;
    localparam logic [1:0] LA_PRE  = 2'd1;
    localparam logic [1:0] LA_POST = 2'd2;
    localparam logic [1:0] LA_READ = 2'd3;

    typedef enum logic [1:0] {
        IDLE = LA_IDLE,
        PRE  = LA_PRE,
        POST = LA_POST,
        READ = LA_READ
    } la_state_e;

    // Stored entry is {run_len, sample}.
    function automatic int unsigned entry_w(input int unsigned ch, input int unsigned ts_w);
        return ch + ts_w;
    endfunction

endpackage

// File: rtl/la_trigger_unit.sv
// Masked pattern compare with optional first-matching-cycle (edge) qualification.
module la_trigger_unit
    import la_pkg::*;
#(
    parameter int unsigned CH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic [CH-1:0] i_ch_in,
    input  logic [CH-1:0] i_pattern,
    input  logic [CH-1:0] i_mask,
    input  logic          i_edge,
    output logic          o_hit
);

    logic w_match;
    logic r_match_q;

    // An all-zero mask makes every sample match.
    assign w_match = ((i_ch_in ^ i_pattern) & i_mask) == '0;
    assign o_hit   = w_match && (!i_edge || !r_match_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_q <= 1'b0;
        end else if (i_clear) begin
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
        end
    end

endmodule

// File: rtl/la_capture_engine.sv
// Multi-channel capture engine: armed trigger, pre/post ring buffer with optional
// run-length entries, and ready/valid readout of the DEPTH-entry window.
module la_capture_engine
    import la_pkg::*;
#(
    parameter int unsigned CH    = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned TS_W  = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned EW   = entry_w(CH, TS_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_arm,
    input  logic          i_abort,
    input  logic [CH-1:0] i_ch_in,
    input  logic [CH-1:0] i_trig_pattern,
    input  logic [CH-1:0] i_trig_mask,
    input  logic          i_trig_edge,
    input  logic          i_rle_en,
    input  logic [AW-1:0] i_pre_cnt,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [EW-1:0] o_rd_data,
    output logic          o_rd_last,
    output logic [1:0]    o_state,
    output logic          o_triggered
);

    localparam logic [TS_W-1:0] MAXRUN  = '1;
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_C  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);

    la_state_e       r_state;
    logic            r_first;
    logic            r_rle_en;
    logic            r_triggered;
    logic            r_rd_valid;
    logic [AW-1:0]   r_pre_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_start_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_rd_cnt;
    logic [AW:0]     r_wr_cnt;
    logic [AW:0]     r_post_cnt;
    logic [CH-1:0]   r_cur;
    logic [TS_W-1:0] r_run;
    logic [EW-1:0]   r_mem [DEPTH];

    logic          w_clear;
    logic          w_hit;
    logic          w_flush;
    logic          w_qual;
    logic          w_accept;
    logic          w_force;
    logic          w_we;
    logic          w_post_done;
    logic          w_rd_fire;
    logic [AW:0]   w_need;
    logic [AW-1:0] w_trig_ptr;

    assign w_clear = (r_state == IDLE) && i_arm;

    la_trigger_unit #(
        .CH (CH)
    ) u_trig (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_ch_in   (i_ch_in),
        .i_pattern (i_trig_pattern),
        .i_mask    (i_trig_mask),
        .i_edge    (i_trig_edge),
        .o_hit     (w_hit)
    );

    assign w_flush     = (i_ch_in != r_cur) || (r_run == MAXRUN) || !r_rle_en;
    assign w_qual      = ({1'b0, r_wr_cnt} + (AW+2)'(1)) >= {2'b00, r_pre_cnt};
    assign w_accept    = (r_state == PRE) && !r_first && w_hit && w_qual;
    assign w_need      = DEPTH_C - {1'b0, r_pre_cnt};
    // One write left: close the pending run next cycle rather than wait for a change.
    assign w_force     = (r_post_cnt == (w_need - CNT_ONE));
    assign w_post_done = ((r_post_cnt + CNT_ONE) == w_need);
    assign w_trig_ptr  = r_wr_ptr + PTR_ONE;
    assign w_rd_fire   = r_rd_valid && i_rd_ready;
    assign w_we        = !i_abort &&
                         (((r_state == PRE) && !r_first && (w_flush || w_accept)) ||
                          ((r_state == POST) && (w_flush || w_force)));

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= {r_run, r_cur};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_first     <= 1'b0;
            r_rle_en    <= 1'b0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_pre_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_start_ptr <= '0;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_post_cnt  <= '0;
            r_cur       <= '0;
            r_run       <= '0;
        end else if (i_abort) begin
            r_state     <= IDLE;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_arm) begin
                        r_state    <= PRE;
                        r_pre_cnt  <= i_pre_cnt;
                        r_rle_en   <= i_rle_en;
                        r_wr_ptr   <= '0;
                        r_wr_cnt   <= '0;
                        r_post_cnt <= '0;
                        r_first    <= 1'b1;
                    end
                end
                PRE: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                        r_cur   <= i_ch_in;
                        r_run   <= '0;
                    end else begin
                        if (w_we) begin
                            r_wr_ptr <= w_trig_ptr;
                            r_cur    <= i_ch_in;
                            r_run    <= '0;
                            if (r_wr_cnt != DEPTH_C) begin
                                r_wr_cnt <= r_wr_cnt + CNT_ONE;
                            end
                        end else begin
                            r_run <= r_run + TS_W'(1);
                        end
                        if (w_accept) begin
                            r_start_ptr <= w_trig_ptr - r_pre_cnt;
                            r_triggered <= 1'b1;
                            r_post_cnt  <= '0;
                            r_state     <= POST;
                        end
                    end
                end
                POST: begin
                    if (w_we) begin
                        r_wr_ptr   <= w_trig_ptr;
                        r_cur      <= i_ch_in;
                        r_run      <= '0;
                        r_post_cnt <= r_post_cnt + CNT_ONE;
                        if (w_post_done) begin
                            r_state    <= READ;
                            r_rd_ptr   <= r_start_ptr;
                            r_rd_cnt   <= '0;
                            r_rd_valid <= 1'b1;
                        end
                    end else begin
                        r_run <= r_run + TS_W'(1);
                    end
                end
                READ: begin
                    if (w_rd_fire) begin
                        if (r_rd_cnt == LAST_C) begin
                            r_state     <= IDLE;
                            r_rd_valid  <= 1'b0;
                            r_triggered <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PTR_ONE;
                            r_rd_cnt <= r_rd_cnt + PTR_ONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated so the (unreset) memory never shows on the bus outside READ.
    assign o_rd_data   = r_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_rd_last   = r_rd_valid && (r_rd_cnt == LAST_C);
    assign o_rd_valid  = r_rd_valid;
    assign o_state     = r_state;
    assign o_triggered = r_triggered;

endmodule

// File: tb/tb_la_capture_engine.sv
// Self-checking bench: captures are predicted from the sample stream by segmenting it into
// runs, locating the qualified trigger and selecting the pre/post window.
module tb_la_capture_engine;

    localparam int CH          = 8;
    localparam int DEPTH       = 16;
    localparam int TS_W        = 8;
    localparam int AW          = 4;
    localparam int EW          = CH + TS_W;
    localparam int MAXRUN      = 255;
    localparam int STIM_MAX    = 1024;
    localparam int MODEL_LIMIT = 20000;

    logic          clk;
    logic          rst_n;
    logic          i_arm;
    logic          i_abort;
    logic [CH-1:0] i_ch_in;
    logic [CH-1:0] i_trig_pattern;
    logic [CH-1:0] i_trig_mask;
    logic          i_trig_edge;
    logic          i_rle_en;
    logic [AW-1:0] i_pre_cnt;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [EW-1:0] o_rd_data;
    logic          o_rd_last;
    logic [1:0]    o_state;
    logic          o_triggered;

    la_capture_engine #(
        .CH    (CH),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_arm          (i_arm),
        .i_abort        (i_abort),
        .i_ch_in        (i_ch_in),
        .i_trig_pattern (i_trig_pattern),
        .i_trig_mask    (i_trig_mask),
        .i_trig_edge    (i_trig_edge),
        .i_rle_en       (i_rle_en),
        .i_pre_cnt      (i_pre_cnt),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_rd_data      (o_rd_data),
        .o_rd_last      (o_rd_last),
        .o_state        (o_state),
        .o_triggered    (o_triggered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CH-1:0] stim [STIM_MAX];
    int            stim_len;
    logic [CH-1:0] cfg_pat;
    logic [CH-1:0] cfg_mask;
    bit            cfg_edge;
    bit            cfg_rle;
    int            cfg_pre;
    logic [EW-1:0] exp_ent [DEPTH];
    int            exp_trig_k;
    int            exp_read_k;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Sample seen in capture cycle i (cycle 0 = first PRE cycle); stream holds its last value.
    function automatic logic [CH-1:0] samp(input int i);
        if (i < stim_len) return stim[i];
        return stim[stim_len-1];
    endfunction

    function automatic bit is_match(input int i);
        return ((samp(i) ^ cfg_pat) & cfg_mask) == '0;
    endfunction

    // Does a new run begin at sample i, given the current run began at sample start?
    function automatic bit seg_break(input int i, input int start);
        return !cfg_rle || (samp(i) != samp(i-1)) || ((i - start) == MAXRUN + 1);
    endfunction

    function automatic bit build_model();
        int starts[$];
        int t;
        int n;
        int need;
        int cnt;
        int seg;
        int s;
        int e;
        t = -1;
        starts.push_back(0);
        for (int i = 1; i < MODEL_LIMIT; i++) begin
            // Runs begun before cycle i = entries available once the pending one is closed.
            if (is_match(i) && (!cfg_edge || !is_match(i-1)) && starts.size() >= cfg_pre) begin
                t = i;
                break;
            end
            if (seg_break(i, starts[starts.size()-1])) starts.push_back(i);
        end
        if (t < 0) return 1'b0;
        n = starts.size();
        for (int j = 0; j < cfg_pre; j++) begin
            s = starts[n-cfg_pre+j];
            e = (n - cfg_pre + j + 1 < n) ? starts[n-cfg_pre+j+1] : t;
            exp_ent[j] = {TS_W'(e - s - 1), samp(s)};
        end
        need = DEPTH - cfg_pre;
        cnt  = 0;
        seg  = t;
        for (int i = t + 1; i < MODEL_LIMIT; i++) begin
            if (cnt == need - 1 || seg_break(i, seg)) begin
                exp_ent[cfg_pre+cnt] = {TS_W'(i - seg - 1), samp(seg)};
                cnt++;
                if (cnt == need) begin
                    exp_read_k = i + 1;
                    break;
                end
                seg = i;
            end
        end
        exp_trig_k = t + 1;
        return cnt == need;
    endfunction

    // mode: 0 full readout, 1 abort during READ, 2 async reset during READ
    task automatic run_capture(input int mode);
        int k;
        int trig_k;
        int read_k;
        int idx;
        int guard;
        if (!build_model()) begin
            cfg_mask = '0;
            cfg_edge = 1'b0;
            void'(build_model());
        end
        @(negedge clk);
        check_val("idle_before_arm", o_state, 0);
        i_trig_pattern = cfg_pat;
        i_trig_mask    = cfg_mask;
        i_trig_edge    = cfg_edge;
        i_rle_en       = cfg_rle;
        i_pre_cnt      = AW'(cfg_pre);
        i_ch_in        = samp(0);
        i_arm          = 1'b1;
        @(negedge clk);
        i_arm     = 1'b0;
        i_rle_en  = ~i_rle_en;
        i_pre_cnt = AW'($urandom);
        check_val("arm_state", o_state, 1);
        i_ch_in = samp(0);
        k = 0;
        trig_k = -1;
        read_k = -1;
        while (read_k < 0 && k < 6000) begin
            @(negedge clk);
            k++;
            if (o_triggered && trig_k < 0) trig_k = k;
            if (o_state == 2'd3) begin
                read_k = k;
            end else begin
                i_ch_in = samp(k);
                i_arm   = ($urandom_range(0, 7) == 0);
            end
        end
        i_arm = 1'b0;
        check_val("trig_cycle", trig_k, exp_trig_k);
        check_val("read_cycle", read_k, exp_read_k);
        if (read_k < 0) return;
        idx = 0;
        guard = 0;
        while (idx < DEPTH && guard < 300) begin
            guard++;
            check_val("rd_valid", o_rd_valid, 1);
            check_val($sformatf("rd_data[%0d]", idx), o_rd_data, exp_ent[idx]);
            check_val($sformatf("rd_last[%0d]", idx), o_rd_last, idx == DEPTH - 1);
            if (mode != 0 && idx == 5) begin
                if (mode == 1) begin
                    i_abort    = 1'b1;
                    i_rd_ready = 1'b1;
                    @(negedge clk);
                    i_abort    = 1'b0;
                    i_rd_ready = 1'b0;
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                end
                check_val("stop_state", o_state, 0);
                check_val("stop_rd_valid", o_rd_valid, 0);
                check_val("stop_triggered", o_triggered, 0);
                if (mode == 2) begin
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                return;
            end
            i_rd_ready = $urandom_range(0, 1);
            @(negedge clk);
            if (i_rd_ready) idx++;
        end
        i_rd_ready = 1'b0;
        check_val("done_state", o_state, 0);
        check_val("done_rd_valid", o_rd_valid, 0);
        check_val("done_triggered", o_triggered, 0);
    endtask

    task automatic gen_random();
        int i;
        int h;
        logic [CH-1:0] v;
        i = 0;
        stim_len = $urandom_range(100, 400);
        while (i < stim_len) begin
            v = CH'($urandom_range(0, 7));
            h = $urandom_range(1, 8);
            for (int j = 0; j < h && i < stim_len; j++) begin
                stim[i] = v;
                i++;
            end
        end
        cfg_pat  = CH'($urandom_range(0, 7));
        cfg_mask = CH'($urandom_range(0, 7));
        cfg_edge = $urandom_range(0, 1);
        cfg_rle  = $urandom_range(0, 1);
        cfg_pre  = $urandom_range(0, DEPTH - 1);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        i_arm          = 1'b0;
        i_abort        = 1'b0;
        i_ch_in        = '0;
        i_trig_pattern = '0;
        i_trig_mask    = '0;
        i_trig_edge    = 1'b0;
        i_rle_en       = 1'b0;
        i_pre_cnt      = '0;
        i_rd_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_state", o_state, 0);
        check_val("rst_rd_valid", o_rd_valid, 0);
        check_val("rst_rd_last", o_rd_last, 0);
        check_val("rst_triggered", o_triggered, 0);
        check_val("rst_rd_data", o_rd_data, 0);
        rst_n = 1'b1;

        // Counting stream, level trigger on 0x20, no RLE, four pre-trigger entries.
        stim_len = 64;
        for (int i = 0; i < stim_len; i++) stim[i] = CH'(i);
        cfg_pat = 8'h20; cfg_mask = 8'hFF; cfg_edge = 0; cfg_rle = 0; cfg_pre = 4;
        run_capture(0);

        // Asynchronous reset while waiting in PRE.
        @(negedge clk);
        i_trig_pattern = 8'hFF; i_trig_mask = 8'hFF; i_ch_in = 8'h00; i_arm = 1'b1;
        @(negedge clk);
        i_arm = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_before_rst", o_state, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_pre_state", o_state, 0);
        check_val("rst_pre_rd_valid", o_rd_valid, 0);
        check_val("rst_pre_triggered", o_triggered, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Long constant run: splits at MAXRUN, remainder closed by the trigger sample.
        stim_len = 340;
        for (int i = 0; i < stim_len; i++) stim[i] = (i < 300) ? 8'h05 : CH'(6 + (i % 4));
        cfg_pat = 8'h06; cfg_mask = 8'hFF; cfg_edge = 0; cfg_rle = 1; cfg_pre = 2;
        run_capture(0);

        // Pattern already matching at arm: edge mode waits for drop-and-return.
        stim_len = 60;
        for (int i = 0; i < stim_len; i++) stim[i] = (i >= 20 && i < 25) ? 8'h00 : 8'h33;
        cfg_pat = 8'h33; cfg_mask = 8'hFF; cfg_edge = 1; cfg_rle = 0; cfg_pre = 0;
        run_capture(0);
        cfg_edge = 0;
        run_capture(0);

        // Matching from the start, but only accepted once eight entries exist.
        stim_len = 40;
        for (int i = 0; i < stim_len; i++) stim[i] = 8'hAA;
        cfg_pat = 8'hAA; cfg_mask = 8'hFF; cfg_edge = 0; cfg_rle = 0; cfg_pre = 8;
        run_capture(0);

        for (int it = 0; it < 10; it++) begin
            gen_random();
            run_capture((it % 4 == 1) ? 1 : ((it % 4 == 3) ? 2 : 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
